// File: rtl/cruzamento_ctrl_if.sv
// -----------------------------------------------------------------------------
// cruzamento_ctrl_if
// Signal bundle between the level-crossing sequencer and its surroundings.
//   approach[1:0]  : train entering track i (level)
//   clear[1:0]     : train leaving track i (level)
//   gate_down_sw   : barrier fully-down limit switch
//   gate_up_sw     : barrier fully-up limit switch
//   semaforo[1:0]  : road light  00 green, 01 yellow, 10 red, 11 flashing red
//   cancela[1:0]   : barrier cmd 00 hold up, 01 lower, 10 hold down, 11 raise
//   occ[1:0]       : per-track occupancy flags
//   fault          : sticky fault indicator
// master = sensor/environment side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface cruzamento_ctrl_if;
   logic [1:0] approach;
   logic [1:0] clear;
   logic       gate_down_sw;
   logic       gate_up_sw;
   logic [1:0] semaforo;
   logic [1:0] cancela;
   logic [1:0] occ;
   logic       fault;

   modport master (
      output approach, clear, gate_down_sw, gate_up_sw,
      input  semaforo, cancela, occ, fault
   );

   modport slave (
      input  approach, clear, gate_down_sw, gate_up_sw,
      output semaforo, cancela, occ, fault
   );
endinterface

// File: rtl/cruzamento_ctrl.sv
// -----------------------------------------------------------------------------
// cruzamento_ctrl
// Sequencer for a two-track railroad level crossing. Tracks per-track train
// occupancy, runs the yellow/red warning timing, commands the barrier and
// supervises its travel with limit switches and a travel timeout. Any
// supervision failure latches the FALHA state until reset.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : cruzamento_ctrl_if.slave (sensors in, light/barrier/status out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module cruzamento_ctrl #(
   parameter int T_AMARELO  = 4,
   parameter int T_VERMELHO = 2,
   parameter int T_MOVE_MAX = 16,
   parameter int CNT_W      = 5
) (
   input  logic               clk,
   input  logic               reset,
   cruzamento_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      LIVRE    = 3'd0,
      AMARELO  = 3'd1,
      VERMELHO = 3'd2,
      DESCENDO = 3'd3,
      FECHADA  = 3'd4,
      SUBINDO  = 3'd5,
      FALHA    = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] LD_AMARELO  = CNT_W'(T_AMARELO - 1);
   localparam logic [CNT_W-1:0] LD_VERMELHO = CNT_W'(T_VERMELHO - 1);
   localparam logic [CNT_W-1:0] LD_MOVE     = CNT_W'(T_MOVE_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [CNT_W-1:0] timer_r, timer_s, timer_dec_s;
   logic [1:0]       occ_r, occ_s;
   logic [1:0]       semaforo_r, semaforo_s;
   logic [1:0]       cancela_r, cancela_s;
   logic             fault_r, fault_s;
   logic             any_s;
   logic             conflict_s;
   logic             timer_zero_s;

   // Occupancy update, train-present summary and saturating timer decrement
   always_comb begin
      // set wins over clear on the same track
      occ_s        = bus.approach | (occ_r & ~bus.clear);
      // uses the live approach so a new train is seen in its arrival cycle
      any_s        = (occ_r != 2'b00) || (bus.approach != 2'b00);
      conflict_s   = bus.gate_down_sw & bus.gate_up_sw;
      timer_zero_s = (timer_r == CNT_ZERO);
      if (timer_zero_s) begin
         timer_dec_s = CNT_ZERO;
      end else begin
         timer_dec_s = timer_r - CNT_ONE;
      end
   end

   // Next-state and timer load logic
   always_comb begin
      state_s = state_r;
      timer_s = timer_dec_s;
      case (state_r)
         LIVRE: begin
            if (any_s) begin
               state_s = AMARELO;
               timer_s = LD_AMARELO;
            end else begin
               state_s = LIVRE;
            end
         end
         AMARELO: begin
            // warning runs to completion even if the train is gone
            if (timer_zero_s) begin
               state_s = VERMELHO;
               timer_s = LD_VERMELHO;
            end else begin
               state_s = AMARELO;
            end
         end
         VERMELHO: begin
            if (timer_zero_s) begin
               state_s = DESCENDO;
               timer_s = LD_MOVE;
            end else begin
               state_s = VERMELHO;
            end
         end
         DESCENDO: begin
            if (conflict_s) begin
               state_s = FALHA;
            end else if (bus.gate_down_sw) begin
               state_s = FECHADA;
            end else if (timer_zero_s) begin
               state_s = FALHA;
            end else begin
               state_s = DESCENDO;
            end
         end
         FECHADA: begin
            if (conflict_s) begin
               state_s = FALHA;
            end else if (!any_s) begin
               state_s = SUBINDO;
               timer_s = LD_MOVE;
            end else begin
               state_s = FECHADA;
            end
         end
         SUBINDO: begin
            // a new train re-lowers the barrier before the up switch counts
            if (conflict_s) begin
               state_s = FALHA;
            end else if (any_s) begin
               state_s = DESCENDO;
               timer_s = LD_MOVE;
            end else if (bus.gate_up_sw) begin
               state_s = LIVRE;
            end else if (timer_zero_s) begin
               state_s = FALHA;
            end else begin
               state_s = SUBINDO;
            end
         end
         FALHA: begin
            state_s = FALHA;
         end
         default: begin
            state_s = FALHA;
         end
      endcase
   end

   // Output decode of the upcoming state, so registered outputs track state
   always_comb begin
      semaforo_s = 2'b11;
      cancela_s  = 2'b10;
      fault_s    = 1'b1;
      case (state_s)
         LIVRE:    begin semaforo_s = 2'b00; cancela_s = 2'b00; fault_s = 1'b0; end
         AMARELO:  begin semaforo_s = 2'b01; cancela_s = 2'b00; fault_s = 1'b0; end
         VERMELHO: begin semaforo_s = 2'b10; cancela_s = 2'b00; fault_s = 1'b0; end
         DESCENDO: begin semaforo_s = 2'b10; cancela_s = 2'b01; fault_s = 1'b0; end
         FECHADA:  begin semaforo_s = 2'b10; cancela_s = 2'b10; fault_s = 1'b0; end
         SUBINDO:  begin semaforo_s = 2'b10; cancela_s = 2'b11; fault_s = 1'b0; end
         FALHA:    begin semaforo_s = 2'b11; cancela_s = 2'b10; fault_s = 1'b1; end
         default:  begin semaforo_s = 2'b11; cancela_s = 2'b10; fault_s = 1'b1; end
      endcase
   end

   // State, timer, occupancy and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= LIVRE;
         timer_r    <= CNT_ZERO;
         occ_r      <= 2'b00;
         semaforo_r <= 2'b00;
         cancela_r  <= 2'b00;
         fault_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         timer_r    <= timer_s;
         occ_r      <= occ_s;
         semaforo_r <= semaforo_s;
         cancela_r  <= cancela_s;
         fault_r    <= fault_s;
      end
   end

   assign bus.semaforo = semaforo_r;
   assign bus.cancela  = cancela_r;
   assign bus.occ      = occ_r;
   assign bus.fault    = fault_r;

endmodule

// File: tb/tb_cruzamento_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cruzamento_ctrl
// Directed scenarios followed by randomized sensor traffic, each cycle checked
// against a phase/elapsed-time reference model of the crossing.
// -----------------------------------------------------------------------------
module tb_cruzamento_ctrl;
   localparam int T_AMARELO  = 4;
   localparam int T_VERMELHO = 2;
   localparam int T_MOVE_MAX = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cruzamento_ctrl_if bus();

   cruzamento_ctrl #(
      .T_AMARELO (T_AMARELO),
      .T_VERMELHO(T_VERMELHO),
      .T_MOVE_MAX(T_MOVE_MAX),
      .CNT_W     (5)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // reference model: phase plus cycles already spent in that phase
   typedef enum int {P_LIVRE, P_AMAR, P_VERM, P_DESC, P_FECH, P_SUB, P_FALHA} ph_t;
   ph_t        m_ph;
   int         m_age;
   logic [1:0] m_occ;
   logic [1:0] sem_tab  [7] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
   logic [1:0] canc_tab [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10};

   int n_vec = 0;
   int n_err = 0;

   task automatic model_reset();
      m_ph  = P_LIVRE;
      m_age = 0;
      m_occ = 2'b00;
   endtask

   task automatic model_step(input logic [1:0] app, input logic [1:0] clr,
                             input logic dsw, input logic usw);
      bit  any;
      bit  gate_phase;
      ph_t nx;
      any        = (m_occ != 2'b00) || (app != 2'b00);
      gate_phase = (m_ph == P_DESC) || (m_ph == P_FECH) || (m_ph == P_SUB) || (m_ph == P_FALHA);
      nx = m_ph;
      if (dsw && usw && gate_phase) nx = P_FALHA;
      else begin
         case (m_ph)
            P_LIVRE: if (any) nx = P_AMAR;
            P_AMAR:  if (m_age + 1 >= T_AMARELO) nx = P_VERM;
            P_VERM:  if (m_age + 1 >= T_VERMELHO) nx = P_DESC;
            P_DESC:  if (dsw) nx = P_FECH; else if (m_age + 1 >= T_MOVE_MAX) nx = P_FALHA;
            P_FECH:  if (!any) nx = P_SUB;
            P_SUB:   if (any) nx = P_DESC; else if (usw) nx = P_LIVRE;
                     else if (m_age + 1 >= T_MOVE_MAX) nx = P_FALHA;
            default: nx = P_FALHA;
         endcase
      end
      m_age = (nx != m_ph) ? 0 : m_age + 1;
      m_ph  = nx;
      m_occ = app | (m_occ & ~clr);
   endtask

   task automatic chk2(input string tag, input logic [1:0] got, input logic [1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic got, input logic exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk2({tag, ".semaforo"}, bus.semaforo, sem_tab[int'(m_ph)]);
      chk2({tag, ".cancela"},  bus.cancela,  canc_tab[int'(m_ph)]);
      chk2({tag, ".occ"},      bus.occ,      m_occ);
      chk1({tag, ".fault"},    bus.fault,    (m_ph == P_FALHA));
   endtask

   task automatic step(input logic [1:0] app, input logic [1:0] clr,
                       input logic dsw, input logic usw);
      @(negedge clk);
      bus.approach     = app;
      bus.clear        = clr;
      bus.gate_down_sw = dsw;
      bus.gate_up_sw   = usw;
      @(posedge clk);
      #1;
      model_step(app, clr, dsw, usw);
      check_model("step");
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.approach = 2'b00; bus.clear = 2'b00;
      bus.gate_down_sw = 1'b0; bus.gate_up_sw = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      check_model("reset");
   endtask

   // reset pulse strictly between clock edges
   task automatic pulse_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk2("async.semaforo", bus.semaforo, 2'b00);
      chk2("async.cancela",  bus.cancela,  2'b00);
      chk2("async.occ",      bus.occ,      2'b00);
      chk1("async.fault",    bus.fault,    1'b0);
      #1 reset = 1'b1;
      model_reset();
   endtask

   task automatic drive_to_fechada(input logic [1:0] app);
      step(app, 2'b00, 1'b0, 1'b0);
      repeat (T_AMARELO + T_VERMELHO) step(2'b00, 2'b00, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b1, 1'b0);
   endtask

   initial begin
      bus.approach = 2'b00; bus.clear = 2'b00;
      bus.gate_down_sw = 1'b0; bus.gate_up_sw = 1'b0;
      model_reset();

      // single train on track 0
      do_reset();
      step(2'b01, 2'b00, 1'b0, 1'b0);
      chk2("t1.yellow_first", bus.semaforo, 2'b01);
      for (int k = 2; k <= 9; k++) begin
         step(2'b00, 2'b00, 1'b0, 1'b0);
         if (k == 4) chk2("t1.yellow_last", bus.semaforo, 2'b01);
         if (k == 5) chk2("t1.red_first",   bus.semaforo, 2'b10);
         if (k == 6) chk2("t1.red_hold",    bus.cancela,  2'b00);
         if (k == 7) chk2("t1.lower",       bus.cancela,  2'b01);
      end
      step(2'b00, 2'b00, 1'b1, 1'b0);
      chk2("t1.closed", bus.cancela, 2'b10);
      step(2'b00, 2'b01, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      chk2("t1.raise", bus.cancela, 2'b11);
      step(2'b00, 2'b00, 1'b0, 1'b1);
      chk2("t1.green", bus.semaforo, 2'b00);
      chk2("t1.up",    bus.cancela,  2'b00);

      // two tracks overlapping
      drive_to_fechada(2'b01);
      step(2'b10, 2'b00, 1'b0, 1'b0);
      step(2'b00, 2'b01, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      chk2("t2.occ",  bus.occ,     2'b10);
      chk2("t2.held", bus.cancela, 2'b10);
      step(2'b00, 2'b10, 1'b0, 1'b0);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      chk2("t2.raise", bus.cancela, 2'b11);

      // re-lower from SUBINDO, then travel timeout from the reloaded timer
      step(2'b10, 2'b00, 1'b0, 1'b1);
      chk2("t3.relower", bus.cancela,  2'b01);
      chk2("t3.red",     bus.semaforo, 2'b10);
      repeat (T_MOVE_MAX - 1) step(2'b00, 2'b00, 1'b0, 1'b0);
      chk2("t4.still_lowering", bus.cancela, 2'b01);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      chk1("t4.fault",    bus.fault,    1'b1);
      chk2("t4.flash",    bus.semaforo, 2'b11);
      chk2("t4.hold_dn",  bus.cancela,  2'b10);
      repeat (3) step(2'b00, 2'b10, 1'b0, 1'b0);
      chk1("t4.sticky", bus.fault, 1'b1);
      chk2("t4.occ_tracks", bus.occ, 2'b00);
      pulse_reset();

      // switch conflict while closed
      do_reset();
      drive_to_fechada(2'b01);
      step(2'b00, 2'b00, 1'b1, 1'b1);
      chk1("t5.conflict", bus.fault, 1'b1);

      // conflict ignored when idle; simultaneous set/clear on track 0
      do_reset();
      step(2'b00, 2'b00, 1'b1, 1'b1);
      chk1("t6.idle_conflict", bus.fault, 1'b0);
      step(2'b01, 2'b01, 1'b0, 1'b0);
      chk2("t6.occ_set_wins", bus.occ,      2'b01);
      chk2("t6.yellow",       bus.semaforo, 2'b01);
      step(2'b00, 2'b00, 1'b0, 1'b0);
      pulse_reset();
      step(2'b00, 2'b00, 1'b0, 1'b0);

      // randomized sensor traffic
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] a, c;
         logic       d, u;
         a = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         c = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         d = ($urandom_range(0, 5) == 0);
         u = ($urandom_range(0, 5) == 0);
         step(a, c, d, u);
         if (m_ph == P_FALHA && m_age > 3) begin
            if (i % 2 == 0) do_reset();
            else pulse_reset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
